// File: rtl/register_file_pkg.sv
// Shared sizing and types for the Harmonica general-purpose register file.
package register_file_pkg;

  localparam int NUM_REGS   = 64;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 6;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One synchronous read port with an enable-gated output register.
// A same-cycle write to the addressed entry is forwarded.
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read_en,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
  input  logic                  i_write_en,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic                  w_bypass;
  logic [DATA_WIDTH-1:0] w_rd_value;
  logic [DATA_WIDTH-1:0] r_rdata;

  // The array still holds the old value this cycle, so forward the write data.
  assign w_bypass   = i_write_en && (i_waddr == i_raddr);
  assign w_rd_value = w_bypass ? i_wdata : i_rf_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_read_en) begin
      r_rdata <= w_rd_value;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/register_file_2r1w.sv
// Harmonica general-purpose register file: NUM_REGS x DATA_WIDTH, two
// registered read ports and one write port; entry 0 is an ordinary register.
module register_file_2r1w
  import register_file_pkg::*;
#(
  parameter int NUM_REGS   = register_file_pkg::NUM_REGS,
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            read_en,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] raddr_0,
  input  logic [ADDR_WIDTH-1:0] raddr_1,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic [DATA_WIDTH-1:0] rdata_1
);

  generate
    if (ADDR_WIDTH != $clog2(NUM_REGS)) begin : g_bad_cfg
      $error("ADDR_WIDTH must equal clog2(NUM_REGS)");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] RF [NUM_REGS];

  logic [ADDR_WIDTH-1:0] w_raddr [2];
  logic [DATA_WIDTH-1:0] w_rf_rd [2];
  logic [DATA_WIDTH-1:0] w_rdata [2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        RF[i] <= '0;
      end
    end else if (write_en) begin
      RF[waddr] <= wdata;
    end
  end

  assign w_raddr[0] = raddr_0;
  assign w_raddr[1] = raddr_1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      assign w_rf_rd[gi] = RF[w_raddr[gi]];

      rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_rd_port (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_read_en  (read_en[gi]),
        .i_raddr    (w_raddr[gi]),
        .i_rf_data  (w_rf_rd[gi]),
        .i_write_en (write_en),
        .i_waddr    (waddr),
        .i_wdata    (wdata),
        .o_rdata    (w_rdata[gi])
      );
    end
  endgenerate

  assign rdata_0 = w_rdata[0];
  assign rdata_1 = w_rdata[1];

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench for register_file_2r1w: directed steps followed by
// random traffic, compared against an array-based reference model.
module tb_register_file_2r1w;
  import register_file_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  read_en = 2'b00;
  logic        write_en = 1'b0;
  logic [5:0]  raddr_0 = '0;
  logic [5:0]  raddr_1 = '0;
  logic [5:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_0;
  logic [31:0] rdata_1;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_rf [64];
  logic [31:0] m_r0;
  logic [31:0] m_r1;

  register_file_2r1w dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .read_en  (read_en),
    .write_en (write_en),
    .raddr_0  (raddr_0),
    .raddr_1  (raddr_1),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata_0  (rdata_0),
    .rdata_1  (rdata_1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_rf[i] = '0;
    m_r0 = '0;
    m_r1 = '0;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s RF[%0d]", tag, i), dut.RF[i], m_rf[i]);
    end
  endtask

  // Drive one cycle of inputs after a falling edge, update the model at the
  // rising edge, then compare both read outputs at the next falling edge.
  task automatic apply(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                       input logic [1:0] re, input logic [5:0] a0, input logic [5:0] a1,
                       input string tag);
    write_en = we; waddr = wa; wdata = wd;
    read_en = re; raddr_0 = a0; raddr_1 = a1;
    @(posedge clk);
    if (re[0]) m_r0 = (we && wa == a0) ? wd : m_rf[a0];
    if (re[1]) m_r1 = (we && wa == a1) ? wd : m_rf[a1];
    if (we) m_rf[wa] = wd;
    @(negedge clk);
    check({tag, " rdata_0"}, rdata_0, m_r0);
    check({tag, " rdata_1"}, rdata_1, m_r1);
  endtask

  task automatic random_burst(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      logic [5:0] a0, a1, wa;
      wa = 6'($urandom_range(0, 63));
      a0 = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
      apply(1'($urandom), wa, $urandom, 2'($urandom), a0, a1, tag);
    end
  endtask

  initial begin
    model_reset();

    // Reset held for 100 ns with the clock running.
    #100;
    check("reset rdata_0", rdata_0, 32'h0);
    check("reset rdata_1", rdata_1, 32'h0);
    check_rf("reset");
    @(negedge clk);
    reset_n = 1'b1;

    apply(1'b1, 6'd5, 32'hDEADBEEF, 2'b00, 6'd0, 6'd0, "write5");
    apply(1'b0, 6'd0, 32'h0, 2'b01, 6'd5, 6'd0, "read5");
    check("read5 value", rdata_0, 32'hDEADBEEF);
    check("read5 port1 idle", rdata_1, 32'h0);

    apply(1'b1, 6'd0, 32'h1, 2'b00, 6'd0, 6'd0, "write0");
    apply(1'b1, 6'd63, 32'hFFFFFFFF, 2'b00, 6'd0, 6'd0, "write63");
    apply(1'b0, 6'd0, 32'h0, 2'b11, 6'd0, 6'd63, "read0_63");
    check("entry0 value", rdata_0, 32'h1);
    check("entry63 value", rdata_1, 32'hFFFFFFFF);

    apply(1'b1, 6'd10, 32'hA5A5A5A5, 2'b11, 6'd10, 6'd10, "bypass");
    check("bypass port0", rdata_0, 32'hA5A5A5A5);
    check("bypass port1", rdata_1, 32'hA5A5A5A5);

    apply(1'b0, 6'd0, 32'h0, 2'b00, 6'd5, 6'd0, "hold");
    check("hold port0", rdata_0, 32'hA5A5A5A5);
    apply(1'b0, 6'd10, 32'h12345678, 2'b00, 6'd1, 6'd2, "nowrite");
    apply(1'b0, 6'd5, 32'h87654321, 2'b00, 6'd3, 6'd4, "nowrite");
    check_rf("nowrite");

    random_burst(400, "random");
    check_rf("random");

    // Asynchronous reset between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async rdata_0", rdata_0, 32'h0);
    check("async rdata_1", rdata_1, 32'h0);
    check_rf("async");

    // Writes and reads during reset must be ignored.
    write_en = 1'b1; waddr = 6'd7; wdata = 32'hCAFEF00D;
    read_en = 2'b11; raddr_0 = 6'd7; raddr_1 = 6'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("held rdata_0", rdata_0, 32'h0);
    check("held rdata_1", rdata_1, 32'h0);
    check("held RF[7]", dut.RF[7], 32'h0);
    reset_n = 1'b1;

    random_burst(200, "post");
    check_rf("post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
